max_scan_ctrl: RTL and testbench

- Avalon-MM slave controller that buffers a block of data words written by the CPU.
- On command, it sequences a one-element-per-cycle max search over the buffer, reporting the maximum value and its index.
- It sits beside the existing max-finder IP on the SoC bus, extending it from a fixed 20-bit combinational search to a programmable-length sequential scan with status and interrupt.

---
 rtl/max_scan_pkg.sv | 22 ++
 rtl/max_scan_ctrl_if.sv | 15 +
 rtl/max_cmp_unit.sv | 42 ++++
 rtl/max_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_max_scan_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/max_scan_pkg.sv
// Shared constants for the max-scan controller: register map, CTRL/STATUS bit
// positions and the scan FSM state encoding.
package max_scan_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_MAX  = 2'd2;
  localparam logic [1:0] ADDR_IDX  = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_IRQ_EN = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_WERR   = 4;
  localparam int ST_EMPTY  = 5;
  localparam int ST_W      = 6;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} scan_state_e;
endpackage

// File: rtl/max_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for max_scan_ctrl (names match the SoC bus).
interface max_scan_ctrl_if;
  logic        iChipselect_n;
  logic        iWrite_n;
  logic        iRead_n;
  logic [1:0]  iAddress;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oIrq;

  modport master (output iChipselect_n, iWrite_n, iRead_n, iAddress, iData,
                  input  oData, oIrq);
  modport slave  (input  iChipselect_n, iWrite_n, iRead_n, iAddress, iData,
                  output oData, oIrq);
endinterface

// File: rtl/max_cmp_unit.sv
// Running max/index register: load seeds with element 0, step keeps the
// earlier index on ties (strict greater-than).
module max_cmp_unit #(
  parameter int DW         = 32,
  parameter int IW         = 4,
  parameter int SIGNED_CMP = 0
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [DW-1:0] i_val,
  input  logic [IW-1:0] i_idx,
  output logic [DW-1:0] o_max,
  output logic [IW-1:0] o_idx
);
  logic [DW-1:0] r_max;
  logic [IW-1:0] r_idx;
  logic          w_gt;

  assign w_gt = (SIGNED_CMP != 0) ? ($signed(i_val) > $signed(r_max)) : (i_val > r_max);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (i_clr) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_max <= i_val;
      r_idx <= '0;
    end else if (i_step && w_gt) begin
      r_max <= i_val;
      r_idx <= i_idx;
    end
  end

  assign o_max = r_max;
  assign o_idx = r_idx;
endmodule

// File: rtl/max_scan_ctrl.sv
// CPU-loaded buffer with a sequential one-element-per-cycle max search,
// reporting value/index through a small Avalon-MM register map.
module max_scan_ctrl
  import max_scan_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 16,
  parameter int SIGNED_CMP = 0
) (
  input  logic           iClk,
  input  logic           iReset_n,
  max_scan_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic w_wr, w_rd, w_push, w_ctrl_wr, w_start, w_clear;
  logic w_busy, w_load, w_step, w_finish, w_empty_start, w_push_ok, w_last;

  scan_state_e r_state, w_state_nxt;
  logic [DW-1:0] r_buf [DEPTH];
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_ptr;
  logic          r_done, r_ovf, r_werr, r_empty, r_irq_en, r_irq;
  logic [31:0]   r_rdata;
  logic [DW-1:0] w_max, w_val;
  logic [PW-1:0] w_idx;
  logic [ST_W-1:0] w_status;

  assign w_wr      = ~bus.iChipselect_n & ~bus.iWrite_n;
  assign w_rd      = ~bus.iChipselect_n & ~bus.iRead_n;
  assign w_push    = w_wr && (bus.iAddress == ADDR_DATA);
  assign w_ctrl_wr = w_wr && (bus.iAddress == ADDR_CTRL);
  assign w_clear   = w_ctrl_wr & bus.iData[CTRL_CLEAR];
  assign w_start   = w_ctrl_wr & bus.iData[CTRL_START] & ~bus.iData[CTRL_CLEAR];
  assign w_last    = ({1'b0, r_ptr} == (r_count - CW'(1)));

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // DONE behaves like IDLE for a fresh START so a back-to-back command is not lost.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE, DONE: w_state_nxt = (w_start && r_count != '0) ? LOAD : IDLE;
        LOAD:       w_state_nxt = (r_count == CW'(1)) ? DONE : SCAN;
        SCAN:       w_state_nxt = w_last ? DONE : SCAN;
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy        = (r_state == LOAD) || (r_state == SCAN);
    w_load        = (r_state == LOAD) && !w_clear;
    w_step        = (r_state == SCAN) && !w_clear;
    w_finish      = (w_state_nxt == DONE);
    w_empty_start = w_start && !w_busy && (r_count == '0);
    w_push_ok     = w_push && !w_busy && (r_count != CW'(DEPTH));
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)   r_ptr <= '0;
    else if (w_load) r_ptr <= PW'(1);
    else if (w_step && !w_last) r_ptr <= r_ptr + PW'(1);
  end

  always_ff @(posedge iClk) begin
    if (w_push_ok) r_buf[r_count[PW-1:0]] <= bus.iData[DW-1:0];
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_count  <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_werr   <= 1'b0;
      r_empty  <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= r_done & r_irq_en;
      if (w_ctrl_wr) r_irq_en <= bus.iData[CTRL_IRQ_EN];
      if (w_clear) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
        r_werr  <= 1'b0;
        r_empty <= 1'b0;
      end else begin
        // A busy push is a write error even when the buffer is also full.
        if (w_push) begin
          if (w_busy)                        r_werr  <= 1'b1;
          else if (r_count == CW'(DEPTH))    r_ovf   <= 1'b1;
          else                               r_count <= r_count + CW'(1);
        end
        if (w_start && !w_busy) begin
          r_done  <= w_empty_start;
          r_empty <= w_empty_start;
        end
        if (w_finish) r_done <= 1'b1;
      end
    end
  end

  assign w_val = w_load ? r_buf[0] : r_buf[r_ptr];

  max_cmp_unit #(.DW(DW), .IW(PW), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .i_clr    (w_empty_start),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_val    (w_val),
    .i_idx    (r_ptr),
    .o_max    (w_max),
    .o_idx    (w_idx)
  );

  always_comb begin
    w_status            = '0;
    w_status[ST_BUSY]   = w_busy;
    w_status[ST_DONE]   = r_done;
    w_status[ST_IRQ_EN] = r_irq_en;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_WERR]   = r_werr;
    w_status[ST_EMPTY]  = r_empty;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_rdata <= '0;
    else if (w_rd) begin
      case (bus.iAddress)
        ADDR_DATA: r_rdata <= 32'(r_count);
        ADDR_CTRL: r_rdata <= 32'(w_status);
        ADDR_MAX:  r_rdata <= 32'(w_max);
        default:   r_rdata <= {16'd0, 16'(w_idx)};
      endcase
    end
  end

  assign bus.oData = r_rdata;
  assign bus.oIrq  = r_irq;
endmodule

// File: tb/tb_max_scan_ctrl.sv
// Bench for max_scan_ctrl: unsigned and signed instances driven in lockstep,
// read expectations queued per instance and checked when oData returns.
module tb_max_scan_ctrl;
  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  max_scan_ctrl_if b0();
  max_scan_ctrl_if b1();

  max_scan_ctrl #(.DW(32), .DEPTH(16), .SIGNED_CMP(0)) u_dut (
    .iClk(iClk), .iReset_n(iReset_n), .bus(b0));
  max_scan_ctrl #(.DW(32), .DEPTH(16), .SIGNED_CMP(1)) u_dut_s (
    .iClk(iClk), .iReset_n(iReset_n), .bus(b1));

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic w, input logic r,
                       input logic [1:0] a, input logic [31:0] d);
    b0.iChipselect_n = cs; b0.iWrite_n = w; b0.iRead_n = r; b0.iAddress = a; b0.iData = d;
    b1.iChipselect_n = cs; b1.iWrite_n = w; b1.iRead_n = r; b1.iAddress = a; b1.iData = d;
  endtask

  // Each bus op is called at a negedge and returns at the next negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d);
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
  endtask

  task automatic rd2(input string tag, input logic [1:0] a,
                     input logic [31:0] e0, input logic [31:0] e1);
    q0.push_back(e0);
    q1.push_back(e1);
    drive(1'b1, 1'b1, 1'b0, a, 32'd0);
    b0.iChipselect_n = 1'b0; b1.iChipselect_n = 1'b0;
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    chk(tag, b0.oData, q0.pop_front());
    chk({tag, "_s"}, b1.oData, q1.pop_front());
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    rd2(tag, a, e, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    logic [31:0] vals8 [8];
    drive(1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    idle(3);
    iReset_n = 1'b1;
    idle(1);

    // reset state
    chk("rst_odata", b0.oData, 32'd0);
    chk("rst_irq", {31'd0, b0.oIrq}, 32'd0);
    rd("rst_count", 2'd0, 32'd0);
    rd("rst_status", 2'd1, 32'd0);
    rd("rst_max", 2'd2, 32'd0);
    rd("rst_idx", 2'd3, 32'd0);

    // 5,9,3,9,1 with irq enabled: exact busy/done timing, first-occurrence index
    wr(2'd0, 5); wr(2'd0, 9); wr(2'd0, 3); wr(2'd0, 9); wr(2'd0, 1);
    rd("t1_count", 2'd0, 32'd5);
    wr(2'd1, 32'h5);
    idle(4);
    rd("t1_busy_last", 2'd1, 32'h05);
    rd("t1_done", 2'd1, 32'h06);
    rd("t1_max", 2'd2, 32'd9);
    rd("t1_idx", 2'd3, 32'd1);
    chk("t1_irq", {31'd0, b0.oIrq}, 32'd1);
    chk("t1_irq_s", {31'd0, b1.oIrq}, 32'd1);
    idle(2);
    chk("t1_odata_hold", b0.oData, 32'd1);

    // signed vs unsigned compare
    wr(2'd1, 32'h2);
    idle(1);
    chk("t2_irq_clr", {31'd0, b0.oIrq}, 32'd0);
    wr(2'd0, 32'hFFFF_FFFF); wr(2'd0, 32'h2); wr(2'd0, 32'h8000_0000);
    wr(2'd1, 32'h1);
    idle(4);
    rd2("t2_max", 2'd2, 32'hFFFF_FFFF, 32'h2);
    rd2("t2_idx", 2'd3, 32'd0, 32'd1);

    // 17 pushes into 16 entries: overflow, last word must not be scanned
    wr(2'd1, 32'h2);
    for (int i = 0; i < 17; i++)
      wr(2'd0, (i == 10) ? 32'd1000 : (i == 16) ? 32'd5000 : 32'(i * 3));
    rd("t3_count", 2'd0, 32'd16);
    rd("t3_ovf", 2'd1, 32'h08);
    wr(2'd1, 32'h1);
    idle(16);
    rd("t3_done", 2'd1, 32'h0A);
    rd("t3_max", 2'd2, 32'd1000);
    rd("t3_idx", 2'd3, 32'd10);
    wr(2'd1, 32'h4);
    idle(2);
    chk("t3_irq", {31'd0, b0.oIrq}, 32'd1);
    wr(2'd1, 32'h2);
    idle(2);
    chk("t3_irq_clr", {31'd0, b0.oIrq}, 32'd0);
    rd("t3_clr_count", 2'd0, 32'd0);
    rd("t3_clr_status", 2'd1, 32'd0);

    // empty start
    wr(2'd1, 32'h1);
    rd("t4_status", 2'd1, 32'h22);
    rd("t4_max", 2'd2, 32'd0);
    rd("t4_idx", 2'd3, 32'd0);

    // mid-scan push, ignored START, then START|CLEAR abort
    wr(2'd1, 32'h2);
    vals8 = '{32'd10, 32'd20, 32'd30, 32'd77, 32'd5, 32'd6, 32'd7, 32'd8};
    for (int i = 0; i < 8; i++) wr(2'd0, vals8[i]);
    wr(2'd1, 32'h1);
    idle(1);
    wr(2'd0, 32'd99);
    rd("t5_count", 2'd0, 32'd8);
    wr(2'd1, 32'h1);
    rd("t5_busy_werr", 2'd1, 32'h11);
    idle(8);
    rd("t5_done", 2'd1, 32'h12);
    rd("t5_max", 2'd2, 32'd77);
    rd("t5_idx", 2'd3, 32'd3);
    wr(2'd1, 32'h1);
    idle(2);
    wr(2'd1, 32'h3);
    rd("t5_abort_status", 2'd1, 32'd0);
    rd("t5_abort_max", 2'd2, 32'd20);
    rd("t5_abort_idx", 2'd3, 32'd1);
    rd("t5_abort_count", 2'd0, 32'd0);

    // reset during a scan
    for (int i = 0; i < 8; i++) wr(2'd0, 32'(100 + i));
    wr(2'd1, 32'h5);
    idle(3);
    iReset_n = 1'b0;
    idle(1);
    iReset_n = 1'b1;
    idle(1);
    chk("t6_odata", b0.oData, 32'd0);
    chk("t6_irq", {31'd0, b0.oIrq}, 32'd0);
    rd("t6_status", 2'd1, 32'd0);
    rd("t6_count", 2'd0, 32'd0);
    rd("t6_max", 2'd2, 32'd0);
    rd("t6_idx", 2'd3, 32'd0);

    // single entry: busy exactly one cycle
    wr(2'd0, 32'h1234);
    wr(2'd1, 32'h1);
    rd("t7_busy", 2'd1, 32'h01);
    rd("t7_done", 2'd1, 32'h02);
    rd("t7_max", 2'd2, 32'h1234);
    rd("t7_idx", 2'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
